change_dispenser: RTL and testbench

//   Sequences the coin hopper that pays out change computed by the vending FSM.

---
 rtl/change_dispenser.sv | 171 +++++++++++++++++
 tb/tb_change_dispenser.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/change_dispenser.sv
// Coin hopper sequencer: splits a change amount greedily into 10/5/1 ejects and tracks per-denomination inventory.
// Latency: one SELECT cycle per coin plus hopper ack time; a zero amount reports done one cycle after accept.
// Backpressure: change_ready is high only in IDLE; FAULT (hopper ack timeout) is absorbing until reset.
// Optional DISPENSE_AUDIT_EN adds paid_total/coin_count running audit counters.
module change_dispenser #(
    parameter int AMT_W       = 32,
    parameter int CNT_W       = 8,
    parameter int INIT_10     = 8,
    parameter int INIT_5      = 8,
    parameter int INIT_1      = 8,
    parameter int ACK_TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             change_valid,
    input  logic [AMT_W-1:0] change_amt,
    output logic             change_ready,
    input  logic             refill_valid,
    input  logic [1:0]       refill_den,
    input  logic [CNT_W-1:0] refill_qty,
    output logic             eject_req,
    output logic [1:0]       eject_den,
    input  logic             eject_ack,
    output logic             busy,
    output logic             done,
    output logic [AMT_W-1:0] shortfall,
    output logic [CNT_W-1:0] inv10,
    output logic [CNT_W-1:0] inv5,
    output logic [CNT_W-1:0] inv1,
    output logic             fault
`ifdef DISPENSE_AUDIT_EN
    ,
    output logic [AMT_W-1:0] paid_total,
    output logic [AMT_W-1:0] coin_count
`endif
);

    localparam int TMO_W = $clog2(ACK_TIMEOUT + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(ACK_TIMEOUT - 1);
    localparam logic [AMT_W-1:0] VAL_10 = AMT_W'(10);
    localparam logic [AMT_W-1:0] VAL_5  = AMT_W'(5);
    localparam logic [AMT_W-1:0] VAL_1  = AMT_W'(1);
    localparam logic [1:0] DEN_1  = 2'b01;
    localparam logic [1:0] DEN_5  = 2'b10;
    localparam logic [1:0] DEN_10 = 2'b11;

    typedef enum logic [2:0] {S_IDLE, S_SELECT, S_WAIT_ACK, S_DONE, S_FAULT} state_t;

    state_t            state;
    logic [AMT_W-1:0]  remaining;
    logic [TMO_W-1:0]  tmo_cnt;
    logic [AMT_W-1:0]  den_amt;
    logic              ack_take;
    logic              pick_10, pick_5, pick_1;

    // Saturating inventory update; a coin is only ejected when cur>0 so the decrement cannot underflow.
    function automatic logic [CNT_W-1:0] inv_next(input logic [CNT_W-1:0] cur, input logic add_en,
                                                  input logic [CNT_W-1:0] qty, input logic dec);
        logic [CNT_W:0] sum;
        sum = {1'b0, cur} + (add_en ? {1'b0, qty} : '0) - {{CNT_W{1'b0}}, dec};
        return sum[CNT_W] ? '1 : sum[CNT_W-1:0];
    endfunction

    assign change_ready = (state == S_IDLE);
    assign busy         = (state != S_IDLE) && (state != S_FAULT);
    assign ack_take     = (state == S_WAIT_ACK) && eject_ack;

    assign pick_10 = (remaining >= VAL_10) && (inv10 != '0);
    assign pick_5  = (remaining >= VAL_5)  && (inv5  != '0);
    assign pick_1  = (remaining >= VAL_1)  && (inv1  != '0);

    // Coin value of the denomination currently being ejected.
    always_comb begin
        den_amt = '0;
        case (eject_den)
            DEN_10:  den_amt = VAL_10;
            DEN_5:   den_amt = VAL_5;
            DEN_1:   den_amt = VAL_1;
            default: den_amt = '0;
        endcase
    end

    // Payout FSM: greedy coin selection, eject handshake, ack timeout and completion reporting.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            remaining <= '0;
            tmo_cnt   <= '0;
            eject_req <= 1'b0;
            eject_den <= 2'b00;
            done      <= 1'b0;
            shortfall <= '0;
            fault     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (change_valid) begin
                        remaining <= change_amt;
                        shortfall <= '0;
                        if (change_amt == '0) begin
                            done  <= 1'b1;
                            state <= S_DONE;
                        end else begin
                            state <= S_SELECT;
                        end
                    end
                end
                S_SELECT: begin
                    tmo_cnt <= '0;
                    if (pick_10 || pick_5 || pick_1) begin
                        eject_den <= pick_10 ? DEN_10 : (pick_5 ? DEN_5 : DEN_1);
                        eject_req <= 1'b1;
                        state     <= S_WAIT_ACK;
                    end else begin
                        shortfall <= remaining;
                        done      <= 1'b1;
                        state     <= S_DONE;
                    end
                end
                S_WAIT_ACK: begin
                    if (eject_ack) begin
                        remaining <= remaining - den_amt;
                        eject_req <= 1'b0;
                        state     <= S_SELECT;
                    end else if (tmo_cnt == TMO_LAST) begin
                        eject_req <= 1'b0;
                        fault     <= 1'b1;
                        shortfall <= remaining;
                        state     <= S_FAULT;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                S_DONE:  state <= S_IDLE;
                S_FAULT: state <= S_FAULT;
                default: state <= S_IDLE;
            endcase
        end
    end

    // Inventory: refills in any state, merged with the ack decrement in one saturating update.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            inv10 <= CNT_W'(INIT_10);
            inv5  <= CNT_W'(INIT_5);
            inv1  <= CNT_W'(INIT_1);
        end else begin
            inv10 <= inv_next(inv10, refill_valid && (refill_den == DEN_10), refill_qty,
                              ack_take && (eject_den == DEN_10));
            inv5  <= inv_next(inv5, refill_valid && (refill_den == DEN_5), refill_qty,
                              ack_take && (eject_den == DEN_5));
            inv1  <= inv_next(inv1, refill_valid && (refill_den == DEN_1), refill_qty,
                              ack_take && (eject_den == DEN_1));
        end
    end

`ifdef DISPENSE_AUDIT_EN
    // Audit counters: running value and number of acked coins, wrapping.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            paid_total <= '0;
            coin_count <= '0;
        end else if (ack_take) begin
            paid_total <= paid_total + den_amt;
            coin_count <= coin_count + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_change_dispenser.sv
// Bench for change_dispenser: directed scenarios plus randomized payouts/refills against a greedy inventory model.
// Hopper is emulated with a programmable ack delay; all waits are bounded.
// Audit outputs are checked when DISPENSE_AUDIT_EN is defined.
module tb_change_dispenser;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        change_valid = 1'b0;
    logic [31:0] change_amt = '0;
    logic        change_ready;
    logic        refill_valid = 1'b0;
    logic [1:0]  refill_den = 2'b00;
    logic [7:0]  refill_qty = '0;
    logic        eject_req;
    logic [1:0]  eject_den;
    logic        eject_ack = 1'b0;
    logic        busy, done, fault;
    logic [31:0] shortfall;
    logic [7:0]  inv10, inv5, inv1;
`ifdef DISPENSE_AUDIT_EN
    logic [31:0] paid_total, coin_count;
`endif

    int total = 0;
    int bad = 0;
    int m10, m5, m1;
    int m_paid, m_cnt;

    change_dispenser dut (
        .clk(clk), .reset(reset),
        .change_valid(change_valid), .change_amt(change_amt), .change_ready(change_ready),
        .refill_valid(refill_valid), .refill_den(refill_den), .refill_qty(refill_qty),
        .eject_req(eject_req), .eject_den(eject_den), .eject_ack(eject_ack),
        .busy(busy), .done(done), .shortfall(shortfall),
        .inv10(inv10), .inv5(inv5), .inv1(inv1), .fault(fault)
`ifdef DISPENSE_AUDIT_EN
        , .paid_total(paid_total), .coin_count(coin_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic int den_val(input logic [1:0] d);
        case (d)
            2'b11:   return 10;
            2'b10:   return 5;
            2'b01:   return 1;
            default: return 0;
        endcase
    endfunction

    function automatic int sat(input int v);
        return (v > 255) ? 255 : v;
    endfunction

    task automatic check_inv(input string tag);
        check({tag, "_inv10"}, int'(inv10), m10);
        check({tag, "_inv5"},  int'(inv5),  m5);
        check({tag, "_inv1"},  int'(inv1),  m1);
    endtask

    task automatic model_reset();
        m10 = 8; m5 = 8; m1 = 8; m_paid = 0; m_cnt = 0;
    endtask

    // Every task starts and ends just after a falling edge.
    task automatic do_reset();
        reset = 1'b1; change_valid = 1'b0; eject_ack = 1'b0; refill_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        @(negedge clk);
        check("rst_req", int'(eject_req), 0);
        check("rst_den", int'(eject_den), 0);
        check("rst_done", int'(done), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_fault", int'(fault), 0);
        check("rst_short", int'(shortfall), 0);
        check("rst_ready", int'(change_ready), 1);
        check_inv("rst");
    endtask

    task automatic refill(input logic [1:0] den, input int qty, input bit stray_ack);
        refill_valid = 1'b1; refill_den = den; refill_qty = 8'(qty); eject_ack = stray_ack;
        @(negedge clk);
        refill_valid = 1'b0; eject_ack = 1'b0;
        case (den)
            2'b11: m10 = sat(m10 + qty);
            2'b10: m5  = sat(m5 + qty);
            2'b01: m1  = sat(m1 + qty);
            default: ;
        endcase
        check_inv("refill");
    endtask

    // One payout with the hopper acking dly cycles after each request; rf10 refills three
    // 10-coins on the same cycle as the final ack.
    task automatic pay(input int amt, input int dly, input bit rf10);
        int exp_q[$];
        int got_q[$];
        int rem, e10, e5, e1, wc, cyc, paid;
        bit busy_ok, gap_ok;
        rem = amt; e10 = m10; e5 = m5; e1 = m1;
        while (1) begin
            if (rem >= 10 && e10 > 0) begin exp_q.push_back(10); rem -= 10; e10--; end
            else if (rem >= 5 && e5 > 0) begin exp_q.push_back(5); rem -= 5; e5--; end
            else if (rem >= 1 && e1 > 0) begin exp_q.push_back(1); rem -= 1; e1--; end
            else break;
        end
        if (rf10 && exp_q.size() > 0) e10 = sat(e10 + 3);

        check("pay_ready", int'(change_ready), 1);
        change_valid = 1'b1; change_amt = 32'(amt);
        @(negedge clk);
        change_valid = 1'b0;
        busy_ok = 1'b1; gap_ok = 1'b1; wc = 0; cyc = 0;
        while (!done && cyc < 2000) begin
            if (!busy) busy_ok = 1'b0;
            if (eject_ack) begin
                eject_ack = 1'b0; refill_valid = 1'b0; wc = 0;
                if (eject_req) gap_ok = 1'b0;
            end else if (eject_req) begin
                if (wc >= dly) begin
                    got_q.push_back(den_val(eject_den));
                    eject_ack = 1'b1;
                    if (rf10 && got_q.size() == exp_q.size()) begin
                        refill_valid = 1'b1; refill_den = 2'b11; refill_qty = 8'd3;
                    end
                end else begin
                    wc++;
                end
            end
            @(negedge clk);
            cyc++;
        end
        if (!busy) busy_ok = 1'b0;
        check("done_seen", int'(done), 1);
        check("busy_held", int'(busy_ok), 1);
        check("req_gap", int'(gap_ok), 1);
        check("ncoins", got_q.size(), exp_q.size());
        paid = 0;
        for (int k = 0; k < exp_q.size(); k++) begin
            check("coin", (k < got_q.size()) ? got_q[k] : -1, exp_q[k]);
            paid += exp_q[k];
        end
        check("shortfall", int'(shortfall), rem);
        m10 = e10; m5 = e5; m1 = e1;
        m_paid += paid; m_cnt += exp_q.size();
        check_inv("pay");
`ifdef DISPENSE_AUDIT_EN
        check("paid_total", int'(paid_total), m_paid);
        check("coin_count", int'(coin_count), m_cnt);
`endif
        @(negedge clk);
        check("done_pulse", int'(done), 0);
        check("idle_ready", int'(change_ready), 1);
        check("hold_short", int'(shortfall), rem);
    endtask

    task automatic timeout_test(input int amt);
        int hi, cyc;
        change_valid = 1'b1; change_amt = 32'(amt);
        @(negedge clk);
        change_valid = 1'b0;
        hi = 0; cyc = 0;
        while (!fault && cyc < 200) begin
            if (eject_req) hi++;
            @(negedge clk);
            cyc++;
        end
        check("tmo_fault", int'(fault), 1);
        check("tmo_req_cycles", hi, 16);
        check("tmo_req", int'(eject_req), 0);
        check("tmo_short", int'(shortfall), amt);
        check("tmo_busy", int'(busy), 0);
        change_valid = 1'b1; change_amt = 32'd5;
        for (int k = 0; k < 3; k++) begin
            check("fault_ready", int'(change_ready), 0);
            @(negedge clk);
            check("fault_req", int'(eject_req), 0);
        end
        change_valid = 1'b0;
        refill(2'b01, 2, 1'b1);
        check("fault_sticky", int'(fault), 1);
        check_inv("tmo");
    endtask

    task automatic reset_mid_test();
        int cyc;
        change_valid = 1'b1; change_amt = 32'd16;
        @(negedge clk);
        change_valid = 1'b0;
        cyc = 0;
        while (!eject_req && cyc < 20) begin @(negedge clk); cyc++; end
        check("mid_first_req", int'(eject_req), 1);
        eject_ack = 1'b1;
        @(negedge clk);
        eject_ack = 1'b0;
        cyc = 0;
        while (!eject_req && cyc < 20) begin @(negedge clk); cyc++; end
        check("mid_second_req", int'(eject_req), 1);
        check("mid_inv10", int'(inv10), 7);
        reset = 1'b1;
        #1;
        check("mid_rst_req", int'(eject_req), 0);
        check("mid_rst_inv10", int'(inv10), 8);
        check("mid_rst_inv5", int'(inv5), 8);
        check("mid_rst_ready", int'(change_ready), 1);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        @(negedge clk);
        check_inv("mid");
    endtask

    initial begin
        model_reset();
        @(negedge clk);
        do_reset();
        pay(6, 1, 1'b0);
        pay(26, 1, 1'b0);
        pay(10, 0, 1'b1);
        refill(2'b01, 250 - m1, 1'b0);
        refill(2'b01, 10, 1'b0);
        pay(0, 0, 1'b0);
        do_reset();
        pay(80, 2, 1'b0);
        pay(35, 0, 1'b0);
        pay(12, 1, 1'b0);
        pay(12, 3, 1'b0);
        do_reset();
        timeout_test(10);
        do_reset();
        reset_mid_test();
        for (int i = 0; i < 30; i++) begin
            if ($urandom_range(0, 2) == 0)
                refill(2'($urandom_range(0, 3)), int'($urandom_range(0, 20)), 1'($urandom_range(0, 1)));
            pay(int'($urandom_range(0, 70)), int'($urandom_range(0, 3)), 1'b0);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
